// File: rtl/chk_pkg.sv
// Shared types and helpers for the port checker: FSM state encodings,
// default begin/end tokens and a width-generic byte-reverse function.
package chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REPORT
    } chkState_t;

    typedef enum logic {
        ARM,
        HOLD
    } armState_t;

    localparam logic [31:0] CHK_BEGIN_SYM = 32'h0000_0168;
    localparam logic [31:0] CHK_END_SYM   = 32'hFFFF_FD5D;

    // Widest bus the byte-reverse helper handles; callers zero-extend into it.
    localparam int CHK_MAX_W = 256;

    function automatic logic [CHK_MAX_W-1:0] byteReverse(
        input logic [CHK_MAX_W-1:0] word,
        input int                   nBytes
    );
        logic [CHK_MAX_W-1:0] result;
        result = '0;
        for (int i = 0; i < CHK_MAX_W / 8; i++) begin
            if (i < nBytes) begin
                result[8*i +: 8] = word[8*(nBytes-1-i) +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/chk_exp_mem.sv
// Expected-word table: one synchronous write port, one asynchronous read
// port, no reset (contents are loaded before each run).
module chk_exp_mem
    import chk_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read sees the pre-edge contents, so a same-cycle write loses.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/port_checker.sv
// Watches bus writes to one address, compares them with a loaded table and
// reports error count, duration and pass. Optional watchdog: PORT_CHECKER_TIMEOUT_EN.
module port_checker
    import chk_pkg::*;
#(
    parameter int                ADDR_W      = 30,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 32,
    parameter int                ERR_W       = 8,
    parameter int                DUR_W       = 16,
    parameter logic [ADDR_W-1:0] TEST_PORT   = 30'h10,
    parameter logic [DATA_W-1:0] BEGIN_SYM   = CHK_BEGIN_SYM,
    parameter logic [DATA_W-1:0] END_SYM     = CHK_END_SYM,
    parameter bit                SWAP        = 1'b1,
    parameter logic [DUR_W-1:0]  TIMEOUT_CYC = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        data,
    input  logic                     wen,
    input  logic                     exp_we,
    input  logic [$clog2(DEPTH)-1:0] exp_idx,
    input  logic [DATA_W-1:0]        exp_data,
    input  logic [$clog2(DEPTH):0]   num_checks,
    output logic [ERR_W-1:0]         error_num,
    output logic [DUR_W-1:0]         duration,
    output logic                     finish,
    output logic                     pass,
    output logic                     timeout,
    output logic [$clog2(DEPTH)-1:0] first_err_idx,
    output logic [DATA_W-1:0]        first_err_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    chkState_t         state_q;
    armState_t         armState_q;
    logic [CNT_W-1:0]  index_q;
    logic [DUR_W-1:0]  duration_q, duration_d;
    logic [ERR_W-1:0]  errorNum_q, errorNum_d;
    logic              timeout_q;
    logic [IDX_W-1:0]  firstErrIdx_q;
    logic [DATA_W-1:0] firstErrData_q;

    logic [CHK_MAX_W-1:0] dataWide, revWide;
    logic [DATA_W-1:0]    obs, expWord;
    logic                 accepted, indexDone, compare, mismatch, timeoutHit;
    logic                 unusedBits;

    always_comb begin
        dataWide             = '0;
        dataWide[DATA_W-1:0] = data;
    end

    assign revWide    = byteReverse(dataWide, DATA_W / 8);
    assign obs        = SWAP ? revWide[DATA_W-1:0] : data;
    assign unusedBits = ^{END_SYM, revWide[CHK_MAX_W-1:DATA_W]};

    chk_exp_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) uExpMem (
        .clk_i   (clk),
        .we_i    (exp_we),
        .waddr_i (exp_idx),
        .wdata_i (exp_data),
        .raddr_i (index_q[IDX_W-1:0]),
        .rdata_o (expWord)
    );

    // Only the first cycle of a wen pulse counts, so stalled writes are seen once.
    assign accepted   = (armState_q == ARM) && wen && (addr == TEST_PORT);
    assign indexDone  = (index_q == num_checks);
    assign compare    = (state_q == CHECK) && accepted && !indexDone;
    assign mismatch   = compare && (obs != expWord);
    assign errorNum_d = (errorNum_q == '1) ? errorNum_q : errorNum_q + ERR_W'(1);
    assign duration_d = (duration_q == '1) ? duration_q : duration_q + DUR_W'(1);

`ifdef PORT_CHECKER_TIMEOUT_EN
    assign timeoutHit = (state_q == CHECK) && (duration_q == TIMEOUT_CYC);
`else
    logic unusedTimeoutCyc;
    assign timeoutHit       = 1'b0;
    assign unusedTimeoutCyc = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            armState_q     <= ARM;
            index_q        <= '0;
            duration_q     <= '0;
            errorNum_q     <= '1;
            timeout_q      <= 1'b0;
            firstErrIdx_q  <= '0;
            firstErrData_q <= '0;
        end else begin
            armState_q <= wen ? HOLD : ARM;
            case (state_q)
                IDLE: begin
                    if (accepted && (obs == BEGIN_SYM)) begin
                        state_q        <= CHECK;
                        index_q        <= '0;
                        duration_q     <= '0;
                        errorNum_q     <= '0;
                        firstErrIdx_q  <= '0;
                        firstErrData_q <= '0;
                    end
                end
                CHECK: begin
                    if (compare) begin
                        index_q <= index_q + CNT_W'(1);
                    end
                    if (mismatch) begin
                        errorNum_q <= errorNum_d;
                        if (errorNum_q == '0) begin
                            firstErrIdx_q  <= index_q[IDX_W-1:0];
                            firstErrData_q <= obs;
                        end
                    end
                    // A watchdog expiry holds duration at the limit it reached.
                    if (timeoutHit) begin
                        timeout_q <= 1'b1;
                        state_q   <= REPORT;
                    end else begin
                        duration_q <= duration_d;
                        if (indexDone) begin
                            state_q <= REPORT;
                        end
                    end
                end
                REPORT: begin
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign error_num      = errorNum_q;
    assign duration       = duration_q;
    assign finish         = (state_q == REPORT);
    assign pass           = finish && (errorNum_q == '0) && !timeout_q;
    assign timeout        = timeout_q;
    assign first_err_idx  = firstErrIdx_q;
    assign first_err_data = firstErrData_q;

endmodule

// File: tb/tb_port_checker.sv
// Self-checking bench for port_checker: a cycle model derived from the
// checker's rules plus hand-computed expectations for each directed run.
module tb_port_checker;

    localparam logic [29:0] PORT    = 30'h10;
    localparam logic [29:0] OTHER   = 30'h11;
    localparam logic [31:0] BEGIN_W = 32'h0000_0168;
    localparam logic [31:0] END_W   = 32'hFFFF_FD5D;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] data = '0;
    logic        wen = 1'b0;
    logic        exp_we = 1'b0;
    logic [4:0]  exp_idx = '0;
    logic [31:0] exp_data = '0;
    logic [5:0]  num_checks = '0;

    logic [7:0]  errorNum;
    logic [15:0] duration;
    logic        finish, pass, timeout;
    logic [4:0]  firstErrIdx;
    logic [31:0] firstErrData;

    logic [1:0]  errorNum2;
    logic [15:0] duration2;
    logic        finish2, pass2, timeout2;
    logic [4:0]  firstErrIdx2;
    logic [31:0] firstErrData2;

    int checks = 0;
    int passes = 0;

    logic [31:0] words [19];

    always #5 clk = ~clk;

    port_checker dut (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
        .num_checks(num_checks), .error_num(errorNum), .duration(duration),
        .finish(finish), .pass(pass), .timeout(timeout),
        .first_err_idx(firstErrIdx), .first_err_data(firstErrData)
    );

    port_checker #(.ERR_W(2), .TIMEOUT_CYC(16'd50)) dut2 (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
        .num_checks(num_checks), .error_num(errorNum2), .duration(duration2),
        .finish(finish2), .pass(pass2), .timeout(timeout2),
        .first_err_idx(firstErrIdx2), .first_err_data(firstErrData2)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model of the default-parameter instance, stepped on the same edge as the DUT.
    int          mPhase = 0;
    int          mIdx = 0;
    int          mErr = 255;
    int          mDur = 0;
    int          mFirstIdx = 0;
    logic [31:0] mFirstData = '0;
    bit          mPrevWen = 1'b0;
    bit          modelLive = 1'b0;
    logic [31:0] mTable [32];

    always @(posedge clk) begin : model
        logic [31:0] seen;
        bit          took;
        seen = {<<8{data}};
        took = wen && !mPrevWen && (addr == PORT);
        if (!rst) begin
            mPhase = 0; mIdx = 0; mErr = 255; mDur = 0;
            mFirstIdx = 0; mFirstData = '0; mPrevWen = 1'b0; modelLive = 1'b1;
        end else begin
            if (mPhase == 0) begin
                if (took && seen == BEGIN_W) begin
                    mPhase = 1; mIdx = 0; mErr = 0; mDur = 0;
                    mFirstIdx = 0; mFirstData = '0;
                end
            end else if (mPhase == 1) begin
                if (mIdx == int'(num_checks)) begin
                    mPhase = 2;
                end else if (took) begin
                    if (seen != mTable[mIdx]) begin
                        if (mErr == 0) begin
                            mFirstIdx = mIdx;
                            mFirstData = seen;
                        end
                        if (mErr < 255) mErr++;
                    end
                    mIdx++;
                end
                if (mDur < 65535) mDur++;
            end
            mPrevWen = wen;
        end
        if (exp_we) mTable[exp_idx] = exp_data;
    end

    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("error_num", 64'(errorNum), 64'(mErr));
            checkOutput("duration", 64'(duration), 64'(mDur));
            checkOutput("finish", 64'(finish), 64'(mPhase == 2));
            checkOutput("pass", 64'(pass), 64'(mPhase == 2 && mErr == 0));
            checkOutput("timeout", 64'(timeout), 64'(0));
            checkOutput("first_err_idx", 64'(firstErrIdx), 64'(mFirstIdx));
            checkOutput("first_err_data", 64'(firstErrData), 64'(mFirstData));
        end
    end

    // Called at a negedge; word is the value the checker should observe.
    task automatic applyStimulus(input logic [29:0] a, input logic [31:0] word, input int hold);
        addr = a;
        data = {<<8{word}};
        wen  = 1'b1;
        repeat (hold) @(negedge clk);
        wen = 1'b0;
        @(negedge clk);
    endtask

    task automatic loadTable();
        for (int i = 0; i < 19; i++) begin
            exp_we = 1'b1; exp_idx = 5'(i); exp_data = words[i];
            @(negedge clk);
        end
        exp_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic runFull(input int hold, input bit corrupt);
        logic [31:0] w;
        applyStimulus(PORT, BEGIN_W, hold);
        for (int i = 0; i < 19; i++) begin
            w = words[i];
            if (corrupt && i == 3) w = 32'hDEAD_BEEF;
            if (corrupt && i == 7) w = BEGIN_W;
            if (i == 5) applyStimulus(OTHER, BEGIN_W, hold);
            applyStimulus(PORT, w, hold);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 18; i++) words[i] = 32'h1000_0000 + 32'(i) * 32'h0102_0304;
        words[18] = END_W;

        @(negedge clk);
        checkOutput("reset error_num", 64'(errorNum), 64'd255);
        checkOutput("reset duration", 64'(duration), 64'd0);
        checkOutput("reset finish", 64'(finish), 64'd0);
        checkOutput("reset first_err_data", 64'(firstErrData), 64'd0);
        checkOutput("reset error_num2", 64'(errorNum2), 64'd3);
        rst = 1'b1;

        $display("[TB] clean run of 19 words");
        loadTable();
        num_checks = 6'd19;
        runFull(1, 1'b0);
        checkOutput("clean finish", 64'(finish), 64'd1);
        checkOutput("clean error_num", 64'(errorNum), 64'd0);
        checkOutput("clean pass", 64'(pass), 64'd1);

        $display("[TB] run with words 3 and 7 corrupted");
        doReset();
        runFull(1, 1'b1);
        checkOutput("corrupt error_num", 64'(errorNum), 64'd2);
        checkOutput("corrupt first_err_idx", 64'(firstErrIdx), 64'd3);
        checkOutput("corrupt first_err_data", 64'(firstErrData), 64'hDEAD_BEEF);
        checkOutput("corrupt pass", 64'(pass), 64'd0);

        $display("[TB] stalled writes");
        doReset();
        runFull(4, 1'b0);
        checkOutput("stall error_num", 64'(errorNum), 64'd0);
        checkOutput("stall pass", 64'(pass), 64'd1);

        $display("[TB] table write during compare");
        doReset();
        num_checks = 6'd2;
        applyStimulus(PORT, BEGIN_W, 1);
        addr = PORT; data = {<<8{words[0]}}; wen = 1'b1;
        exp_we = 1'b1; exp_idx = 5'd0; exp_data = 32'hCAFE_F00D;
        @(negedge clk);
        wen = 1'b0; exp_we = 1'b0;
        @(negedge clk);
        applyStimulus(PORT, words[1], 1);
        repeat (2) @(negedge clk);
        checkOutput("same-cycle write error_num", 64'(errorNum), 64'd0);
        checkOutput("same-cycle write pass", 64'(pass), 64'd1);
        loadTable();

        $display("[TB] zero checks");
        doReset();
        num_checks = 6'd0;
        applyStimulus(PORT, BEGIN_W, 1);
        checkOutput("zero checks finish", 64'(finish), 64'd1);
        checkOutput("zero checks duration", 64'(duration), 64'd1);

        $display("[TB] error counter saturation");
        doReset();
        num_checks = 6'd6;
        applyStimulus(PORT, BEGIN_W, 1);
        for (int i = 0; i < 5; i++) applyStimulus(PORT, 32'h0BAD_0000 + 32'(i), 1);
        applyStimulus(PORT, words[5], 1);
        repeat (2) @(negedge clk);
        checkOutput("sat error_num wide", 64'(errorNum), 64'd5);
        checkOutput("sat error_num2", 64'(errorNum2), 64'd3);
        checkOutput("sat first_err_idx2", 64'(firstErrIdx2), 64'd0);
        checkOutput("sat first_err_data2", 64'(firstErrData2), 64'h0BAD_0000);
        checkOutput("sat pass2", 64'(pass2), 64'd0);

        $display("[TB] idle after begin");
        doReset();
        num_checks = 6'd19;
        applyStimulus(PORT, BEGIN_W, 1);
        repeat (60) @(negedge clk);
`ifdef PORT_CHECKER_TIMEOUT_EN
        checkOutput("watchdog timeout2", 64'(timeout2), 64'd1);
        checkOutput("watchdog duration2", 64'(duration2), 64'd50);
        checkOutput("watchdog finish2", 64'(finish2), 64'd1);
        checkOutput("watchdog pass2", 64'(pass2), 64'd0);
`else
        checkOutput("no watchdog timeout2", 64'(timeout2), 64'd0);
        checkOutput("no watchdog duration2", 64'(duration2), 64'd61);
        checkOutput("no watchdog finish2", 64'(finish2), 64'd0);
`endif

        $display("[TB] reset mid-run then rerun");
        doReset();
        applyStimulus(PORT, BEGIN_W, 1);
        for (int i = 0; i < 10; i++) applyStimulus(PORT, words[i], 1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset error_num", 64'(errorNum), 64'd255);
        checkOutput("midreset finish", 64'(finish), 64'd0);
        checkOutput("midreset duration", 64'(duration), 64'd0);
        rst = 1'b1;
        runFull(1, 1'b0);
        checkOutput("rerun pass", 64'(pass), 64'd1);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
